uart_rx_fifo: RTL and testbench

UART receiver with a small byte FIFO that sits directly upstream of the UART-to-SDRAM command parser. It deserialises 8N1 frames from the RX pin, buffers completed bytes, and presents them to the parser through a strobe/acknowledge handshake. It also flags framing errors and FIFO overruns for the status logic.

---
 rtl/uart_rx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO with strobe/ack output.
// Framing errors and FIFO overruns are reported as one-cycle pulses.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_stb,
    input  logic       i_ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;

    logic            bit_end;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            wr_en;

    assign bit_end  = (timer == T_LAST);
    assign push_req = (state == S_STOP) && bit_end && rx_s;
    assign pop      = o_stb && i_ack;
    assign full     = (count == CNT_FULL);
    assign wr_en    = push_req && (!full || pop);
    assign o_stb    = (count != '0);
    assign o_data   = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        timer <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (timer == T_HALF) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift[bit_idx] <= rx_s;
                        timer          <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A push into a full FIFO still lands when the head is popped that cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && full && !pop;
            if (wr_en) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, expected bytes queued,
// a negedge monitor compares every popped byte and counts error pulses.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx = 1'b1;
    logic       i_ack = 1'b0;
    logic [7:0] o_data;
    logic       o_stb;
    logic       frame_err;
    logic       overrun;

    logic [7:0] exp_q [$];
    int n_cmp  = 0;
    int n_err  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rx       (rx),
        .o_data   (o_data),
        .o_stb    (o_stb),
        .i_ack    (i_ack),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 CLK = ~CLK;

    // Monitor: a pop occurs at the next rising edge whenever o_stb & i_ack
    always @(negedge CLK) begin
        logic [7:0] e;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (o_stb && i_ack) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected got=%02h req=none", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    n_err++;
                    $display("FAIL pop_data got=%02h req=%02h", o_data, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s got=%0h req=%0h", name, act, req);
        end
    endtask

    // Stop-sample edge lands 156 cycles after the start bit is driven;
    // ack_edge raises i_ack so it is seen on exactly that edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic ack_edge);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_v;
        if (ack_edge) begin
            tick(11);
            i_ack = 1'b1;
            tick(CPB - 11);
        end else begin
            tick(CPB);
        end
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain got=%0d_left req=0_left", name,
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        tick(2);
        check("rst_stb", {31'd0, o_stb}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        RST = 1'b0;
        tick(5);

        // Back-to-back bytes, parser always ready
        i_ack = 1'b1;
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h57);
        send_frame(8'h52, 1'b1, 1'b0);
        send_frame(8'h57, 1'b1, 1'b0);
        wait_drain("b2b");
        tick(4);
        check("b2b_ferr", fe_cnt, 32'd0);
        check("b2b_ovr", ov_cnt, 32'd0);

        // Short low glitch must be rejected at the start check
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_stb", {31'd0, o_stb}, 32'd0);
        check("glitch_ferr", fe_cnt, 32'd0);

        // Bad stop bit with line held low, then recovery
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = 8'hA5 >> i;
            tick(CPB);
        end
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
        tick(32);
        check("ferr_count", fe_cnt, 32'd1);
        check("ferr_stb", {31'd0, o_stb}, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_drain("after_ferr");
        check("after_ferr_cnt", fe_cnt, 32'd1);

        // Overrun on the fifth byte with the parser stalled
        i_ack = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        tick(4);
        check("ovr_count", ov_cnt, 32'd1);
        check("ovr_stb", {31'd0, o_stb}, 32'd1);
        i_ack = 1'b1;
        wait_drain("ovr");
        tick(2);
        check("ovr_empty", {31'd0, o_stb}, 32'd0);

        // Full FIFO, pop coincides with the fifth push
        i_ack = 1'b0;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1);
        wait_drain("full_pop");
        tick(2);
        check("full_pop_ovr", ov_cnt, 32'd1);

        // Reset during data bit 4 with a stale byte buffered
        i_ack = 1'b0;
        send_frame(8'h99, 1'b1, 1'b0);
        tick(2);
        check("stale_stb", {31'd0, o_stb}, 32'd1);
        check("stale_data", {24'd0, o_data}, 32'h99);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 8'h7E >> i;
            tick(CPB);
        end
        rx = 1'b0;
        tick(CPB / 2);
        RST = 1'b1;
        #1;
        check("mid_rst_stb", {31'd0, o_stb}, 32'd0);
        check("mid_rst_data", {24'd0, o_data}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        rx = 1'b1;
        tick(3);
        RST = 1'b0;
        tick(20);
        i_ack = 1'b1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        wait_drain("post_rst");
        tick(2);
        check("post_rst_ferr", fe_cnt, 32'd1);
        check("post_rst_ovr", ov_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
